cordic_gain_comp: RTL and testbench

Downstream stage of the rotational CORDIC. Captures the final `XN`/`YN`/`ZN` vector when the CORDIC's `Done` pulses and multiplies X and Y by the CORDIC gain-compensation constant K ≈ 0.607253. The multiply is a sequential shift-and-add, one multiplier bit per cycle. The block presents the scaled Q6.12 result with a one-cycle valid pulse, and has a one-deep pending buffer so back-to-back CORDIC results are not lost.

---
 rtl/cordic_gain_comp_if.sv | 32 +++
 rtl/cordic_gain_comp.sv | 202 ++++++++++++++++++++
 tb/tb_cordic_gain_comp.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_gain_comp_if.sv
// +--------------------------------------------------------------------------+
// | cordic_gain_comp_if : sample/result bus between CORDIC and gain stage      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cordic_gain_comp_if #(
  parameter int WORD_LENGTH = 18
);
  logic                   IN_VALID;
  logic [WORD_LENGTH-1:0] XN;
  logic [WORD_LENGTH-1:0] YN;
  logic [WORD_LENGTH-1:0] ZN;
  logic [WORD_LENGTH-1:0] XK;
  logic [WORD_LENGTH-1:0] YK;
  logic [WORD_LENGTH-1:0] ZK;
  logic                   OUT_VALID;
  logic                   BUSY;
  logic                   OVERRUN;

  modport master (
    output IN_VALID, XN, YN, ZN,
    input  XK, YK, ZK, OUT_VALID, BUSY, OVERRUN
  );

  modport slave (
    input  IN_VALID, XN, YN, ZN,
    output XK, YK, ZK, OUT_VALID, BUSY, OVERRUN
  );
endinterface

`default_nettype wire

// File: rtl/cordic_gain_comp.sv
// +--------------------------------------------------------------------------+
// | cordic_gain_comp : scales CORDIC X/Y by K with a bit-serial multiply,      |
// | one-deep pending buffer. Define CORDIC_GAIN_ROUND_EN for round-half-up.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cordic_gain_comp #(
  parameter int                WORD_LENGTH = 18,
  parameter int                FRAC_BITS   = 12,
  parameter int                K_BITS      = 12,
  parameter logic [K_BITS-1:0] K_CONST     = 12'h9B7
) (
  input wire logic          CLK,
  input wire logic          RST,
  cordic_gain_comp_if.slave bus
);

  localparam int ACC_W  = WORD_LENGTH + K_BITS;
  localparam int STEP_W = $clog2(K_BITS + 1);
  localparam logic [STEP_W-1:0] c_LAST = STEP_W'(K_BITS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [STEP_W-1:0]       r_step;
  logic [K_BITS-1:0]       r_kbits;
  logic signed [ACC_W-1:0] r_mx;
  logic signed [ACC_W-1:0] r_my;
  logic signed [ACC_W-1:0] r_acc_x;
  logic signed [ACC_W-1:0] r_acc_y;
  logic [WORD_LENGTH-1:0]  r_z;

  logic                    r_pend_vld;
  logic [WORD_LENGTH-1:0]  r_pend_x;
  logic [WORD_LENGTH-1:0]  r_pend_y;
  logic [WORD_LENGTH-1:0]  r_pend_z;

  logic [WORD_LENGTH-1:0]  r_xk;
  logic [WORD_LENGTH-1:0]  r_yk;
  logic [WORD_LENGTH-1:0]  r_zk;
  logic                    r_out_valid;
  logic                    r_overrun;

  logic                    w_load;
  logic                    w_load_pend;
  logic                    w_pend_wr;
  logic                    w_pend_clr;
  logic                    w_step;
  logic                    w_finish;
  logic                    w_drop;

  logic [WORD_LENGTH-1:0]  w_src_x;
  logic [WORD_LENGTH-1:0]  w_src_y;
  logic [WORD_LENGTH-1:0]  w_src_z;
  logic signed [ACC_W-1:0] w_rnd_x;
  logic signed [ACC_W-1:0] w_rnd_y;
  logic [WORD_LENGTH-1:0]  w_xk;
  logic [WORD_LENGTH-1:0]  w_yk;
  logic                    w_unused_lsbs;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // On the finish edge a waiting sample (pending or arriving) restarts MUL directly.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_pend = 1'b0;
    w_pend_wr   = 1'b0;
    w_pend_clr  = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.IN_VALID) begin
          w_load      = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (r_step == c_LAST) begin
          w_finish = 1'b1;
          if (r_pend_vld) begin
            w_load      = 1'b1;
            w_load_pend = 1'b1;
            w_pend_wr   = bus.IN_VALID;
            w_pend_clr  = !bus.IN_VALID;
          end else if (bus.IN_VALID) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_step = 1'b1;
          if (bus.IN_VALID) begin
            w_pend_wr = !r_pend_vld;
            w_drop    = r_pend_vld;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_src_x = w_load_pend ? r_pend_x : bus.XN;
  assign w_src_y = w_load_pend ? r_pend_y : bus.YN;
  assign w_src_z = w_load_pend ? r_pend_z : bus.ZN;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_step      <= '0;
      r_kbits     <= '0;
      r_mx        <= '0;
      r_my        <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_z         <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_z    <= '0;
      r_xk        <= '0;
      r_yk        <= '0;
      r_zk        <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= w_finish;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_finish) begin
        r_xk <= w_xk;
        r_yk <= w_yk;
        r_zk <= r_z;
      end
      // Operands are pre-shifted one place per step so no barrel shifter is needed.
      if (w_load) begin
        r_mx    <= {{K_BITS{w_src_x[WORD_LENGTH-1]}}, w_src_x};
        r_my    <= {{K_BITS{w_src_y[WORD_LENGTH-1]}}, w_src_y};
        r_z     <= w_src_z;
        r_acc_x <= '0;
        r_acc_y <= '0;
        r_step  <= '0;
        r_kbits <= K_CONST;
      end else if (w_step) begin
        if (r_kbits[0]) begin
          r_acc_x <= r_acc_x + r_mx;
          r_acc_y <= r_acc_y + r_my;
        end
        r_mx    <= r_mx <<< 1;
        r_my    <= r_my <<< 1;
        r_kbits <= r_kbits >> 1;
        r_step  <= r_step + STEP_W'(1);
      end
      if (w_pend_wr) begin
        r_pend_vld <= 1'b1;
        r_pend_x   <= bus.XN;
        r_pend_y   <= bus.YN;
        r_pend_z   <= bus.ZN;
      end else if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [ACC_W-1:0] c_HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
  assign w_rnd_x = r_acc_x + c_HALF;
  assign w_rnd_y = r_acc_y + c_HALF;
`else
  assign w_rnd_x = r_acc_x;
  assign w_rnd_y = r_acc_y;
`endif

  // Taking the slice above the fraction is the arithmetic shift plus truncation.
  assign w_xk          = w_rnd_x[FRAC_BITS +: WORD_LENGTH];
  assign w_yk          = w_rnd_y[FRAC_BITS +: WORD_LENGTH];
  assign w_unused_lsbs = &{1'b0, w_rnd_x[FRAC_BITS-1:0], w_rnd_y[FRAC_BITS-1:0]};

  assign bus.XK        = r_xk;
  assign bus.YK        = r_yk;
  assign bus.ZK        = r_zk;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.BUSY      = (r_state == S_MUL);
  assign bus.OVERRUN   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_cordic_gain_comp.sv
// +--------------------------------------------------------------------------+
// | tb_cordic_gain_comp : self-checking bench against a cycle-level model      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cordic_gain_comp;

  localparam int WL  = 18;
  localparam int FB  = 12;
  localparam int KB  = 12;
  localparam int KC  = 2487;
  localparam int LAT = KB + 1;
  localparam int NS  = 200;

  logic CLK_tb = 1'b0;
  logic RST_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  cordic_gain_comp_if #(.WORD_LENGTH(WL)) bus();

  cordic_gain_comp #(
    .WORD_LENGTH (WL),
    .FRAC_BITS   (FB),
    .K_BITS      (KB),
    .K_CONST     (12'h9B7)
  ) dut (
    .CLK (CLK_tb),
    .RST (RST_tb),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  bit          s_vld [NS];
  logic [WL-1:0] s_x [NS];
  logic [WL-1:0] s_y [NS];
  logic [WL-1:0] s_z [NS];
  int          pulse_q[$];

  // Real-valued K scaling: floor(v * K), optionally with half-LSB rounding.
  function automatic logic [WL-1:0] ref_scale(input logic [WL-1:0] v);
    longint p;
    p = longint'($signed(v)) * KC;
`ifdef CORDIC_GAIN_ROUND_EN
    p = p + (longint'(1) << (FB - 1));
`endif
    p = p >>> FB;
    return p[WL-1:0];
  endfunction

  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic apply_reset();
    bus.IN_VALID = 1'b0;
    RST_tb = 1'b0;
    repeat (2) @(posedge CLK_tb);
    @(negedge CLK_tb);
    RST_tb = 1'b1;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < NS; i++) begin
      s_vld[i] = 1'b0;
      s_x[i] = '0;
      s_y[i] = '0;
      s_z[i] = '0;
    end
    pulse_q.delete();
  endtask

  task automatic put(input int t, input logic [WL-1:0] x, input logic [WL-1:0] y,
                     input logic [WL-1:0] z);
    s_vld[t] = 1'b1;
    s_x[t] = x;
    s_y[t] = y;
    s_z[t] = z;
  endtask

  // Plays the schedule cycle by cycle and compares against a job/time model.
  task automatic run_schedule(input int n, input string tag);
    bit            act = 0, pv = 0, ovr = 0, exp_ov;
    int            fin = 0;
    logic [WL-1:0] ax = 0, ay = 0, az = 0, px = 0, py = 0, pz = 0;
    logic [WL-1:0] lx = 0, ly = 0, lz = 0;
    for (int t = 0; t < n; t++) begin
      bus.IN_VALID = s_vld[t];
      bus.XN = s_x[t];
      bus.YN = s_y[t];
      bus.ZN = s_z[t];
      exp_ov = 1'b0;
      if (act && t == fin) begin
        exp_ov = 1'b1;
        lx = ref_scale(ax);
        ly = ref_scale(ay);
        lz = az;
        if (pv) begin
          ax = px; ay = py; az = pz;
          fin = t + LAT;
          pv = s_vld[t];
          if (s_vld[t]) begin
            px = s_x[t]; py = s_y[t]; pz = s_z[t];
          end
        end else if (s_vld[t]) begin
          ax = s_x[t]; ay = s_y[t]; az = s_z[t];
          fin = t + LAT;
        end else begin
          act = 1'b0;
        end
      end else if (act) begin
        if (s_vld[t]) begin
          if (!pv) begin
            pv = 1'b1;
            px = s_x[t]; py = s_y[t]; pz = s_z[t];
          end else begin
            ovr = 1'b1;
          end
        end
      end else if (s_vld[t]) begin
        act = 1'b1;
        ax = s_x[t]; ay = s_y[t]; az = s_z[t];
        fin = t + LAT;
      end
      tick();
      bus.IN_VALID = 1'b0;
      checks++;
      if (bus.OUT_VALID !== exp_ov || bus.XK !== lx || bus.YK !== ly || bus.ZK !== lz) begin
        errors++;
        $display("FAIL %s result @%0d: got v=%b x=%h y=%h z=%h, want v=%b x=%h y=%h z=%h",
                 tag, t, bus.OUT_VALID, bus.XK, bus.YK, bus.ZK, exp_ov, lx, ly, lz);
      end
      checks++;
      if (bus.BUSY !== act || bus.OVERRUN !== ovr) begin
        errors++;
        $display("FAIL %s status @%0d: got busy=%b ovr=%b, want busy=%b ovr=%b",
                 tag, t, bus.BUSY, bus.OVERRUN, act, ovr);
      end
      if (bus.OUT_VALID === 1'b1) pulse_q.push_back(t);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.XK !== '0 || bus.YK !== '0 || bus.ZK !== '0 ||
        bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got x=%h y=%h z=%h v=%b b=%b o=%b, want all 0",
               bus.XK, bus.YK, bus.ZK, bus.OUT_VALID, bus.BUSY, bus.OVERRUN);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    clear_sched();
    put(0, 18'h01000, 18'h02000, 18'h00005);
    run_schedule(20, "basic");
    checks++;
    if (pulse_q.size() != 1 || pulse_q[0] != LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d pulses first=%0d, want 1 at %0d",
               pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : -1, LAT);
    end
    checks++;
    if (bus.XK !== 18'h009B7 || bus.YK !== 18'h0136E || bus.ZK !== 18'h00005) begin
      errors++;
      $display("FAIL basic_values: got x=%h y=%h z=%h, want x=009b7 y=0136e z=00005",
               bus.XK, bus.YK, bus.ZK);
    end
  endtask

  task automatic test_negative();
    apply_reset();
    clear_sched();
    put(0, 18'h3D000, 18'h3C000, 18'h3FFFF);
    run_schedule(18, "negative");
    checks++;
    if (bus.XK !== 18'h3E2DB || bus.YK !== ref_scale(18'h3C000)) begin
      errors++;
      $display("FAIL negative_values: got x=%h y=%h, want x=3e2db y=%h",
               bus.XK, bus.YK, ref_scale(18'h3C000));
    end
  endtask

  task automatic test_rounding();
    logic [WL-1:0] want;
`ifdef CORDIC_GAIN_ROUND_EN
    want = 18'h00002;
`else
    want = 18'h00001;
`endif
    apply_reset();
    clear_sched();
    put(0, 18'h00003, 18'h3FFFD, 18'h00000);
    run_schedule(18, "rounding");
    checks++;
    if (bus.XK !== want) begin
      errors++;
      $display("FAIL rounding: got x=%h, want %h", bus.XK, want);
    end
  endtask

  task automatic test_random();
    int t;
    apply_reset();
    clear_sched();
    t = 0;
    while (t < NS - 40) begin
      put(t, WL'($urandom), WL'($urandom), WL'($urandom));
      t = t + 1 + int'($urandom_range(0, 16));
    end
    run_schedule(NS, "random");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    clear_sched();
    put(0, 18'h01800, 18'h3F000, 18'h00011);
    put(4, 18'h3E800, 18'h00C00, 18'h00022);
    put(13, 18'h1FFFF, 18'h20000, 18'h00033);
    run_schedule(45, "b2b");
    checks++;
    if (pulse_q.size() != 3 || pulse_q[0] != 13 || pulse_q[1] != 26 || pulse_q[2] != 39 ||
        bus.OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses ovr=%b, want 3 at 13/26/39 ovr=0",
               pulse_q.size(), bus.OVERRUN);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    clear_sched();
    put(0, 18'h00400, 18'h00800, 18'h00001);
    put(2, 18'h00C00, 18'h01000, 18'h00002);
    put(4, 18'h01400, 18'h01800, 18'h00003);
    run_schedule(45, "overrun");
    checks++;
    if (pulse_q.size() != 2 || bus.OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL overrun: got %0d pulses ovr=%b, want 2 pulses ovr=1",
               pulse_q.size(), bus.OVERRUN);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.IN_VALID = 1'b1;
    bus.XN = 18'h05000;
    bus.YN = 18'h06000;
    bus.ZN = 18'h00007;
    tick();
    bus.IN_VALID = 1'b0;
    repeat (5) tick();
    #2;
    RST_tb = 1'b0;
    #1;
    checks++;
    if (bus.BUSY !== 1'b0 || bus.OUT_VALID !== 1'b0 || bus.XK !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b v=%b x=%h, want 0/0/0",
               bus.BUSY, bus.OUT_VALID, bus.XK);
    end
    @(negedge CLK_tb);
    RST_tb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet @%0d: got v=%b busy=%b, want 0/0",
                 i, bus.OUT_VALID, bus.BUSY);
      end
    end
  endtask

  initial begin
    bus.IN_VALID = 1'b0;
    bus.XN = '0;
    bus.YN = '0;
    bus.ZN = '0;
    test_reset();
    test_basic();
    test_negative();
    test_rounding();
    test_back_to_back();
    test_overrun();
    test_random();
    test_reset_mid();
    test_basic();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
